// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one external 4-bit adder slice,
// feeding it one nibble per clock (LSB first) and chaining the carry through a flop.
module nibble_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       add_r1,
  output logic [3:0]       add_r2,
  output logic             add_ci,
  input  logic [3:0]       add_result,
  input  logic             add_carry
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = RUN;
      RUN:     if (k_q == K_LAST) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so B is inverted once at accept and the carry seeded with 1.
  always_comb begin
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d      = op_a;
          b_d      = sub ? ~op_b : op_b;
          carry_d  = sub ? 1'b1 : cin;
          k_d      = '0;
          result_d = '0;
        end
      end
      RUN: begin
        result_d[4*k_q +: 4] = add_result;
        carry_d              = add_carry;
        k_d                  = k_q + 1'b1;
        if (k_q == K_LAST) begin
          cout_d = add_carry;
          ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_result[3] != a_q[WIDTH-1]);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    res_valid = (state_q == DONE);
    result    = result_q;
    cout      = cout_q;
    ovf       = ovf_q;
    add_r1    = 4'h0;
    add_r2    = 4'h0;
    add_ci    = 1'b0;
    if (state_q == RUN) begin
      add_r1 = a_q[4*k_q +: 4];
      add_r2 = b_q[4*k_q +: 4];
      add_ci = carry_q;
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq (WIDTH=32) with a behavioural 4-bit adder slice.
module tb_nibble_add_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic [3:0]       add_r1;
  logic [3:0]       add_r2;
  logic             add_ci;
  logic [3:0]       add_result;
  logic             add_carry;
  logic [4:0]       add_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign add_sum    = {1'b0, add_r1} + {1'b0, add_r2} + {4'b0, add_ci};
  assign add_result = add_sum[3:0];
  assign add_carry  = add_sum[4];

  nibble_add_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .cout(cout), .ovf(ovf),
    .add_r1(add_r1), .add_r2(add_r2), .add_ci(add_ci),
    .add_result(add_result), .add_carry(add_carry)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge with the block idle; returns #1 after the edge where
  // res_valid rose (or the cycle budget ran out). lat counts edges after the accept edge.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic sb,
                        output int lat, output logic [7:0] ci_trace);
    op_a = a; op_b = b; cin = ci; sub = sb; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    op_b = ~b; cin = ~ci; sub = ~sb;
    lat = 0;
    ci_trace = '0;
    while (!res_valid && lat < 20) begin
      if (lat < 8) ci_trace[lat] = add_ci;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"}, 64'(req_ready), 64'h1);
    check({tag, ".res_valid"}, 64'(res_valid), 64'h0);
    check({tag, ".result"},    64'(result),    64'h0);
    check({tag, ".cout"},      64'(cout),      64'h0);
    check({tag, ".ovf"},       64'(ovf),       64'h0);
    check({tag, ".add_bus"},   64'({add_r1, add_r2, add_ci}), 64'h0);
  endtask

  int         lat;
  logic [7:0] trace;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, lat, trace);
    check("add5.lat",    64'(lat),    64'd8);
    check("add5.result", 64'(result), 64'h0000_000A);
    check("add5.cout",   64'(cout),   64'h0);
    check("add5.ovf",    64'(ovf),    64'h0);
    check("add5.req_ready_done", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    check("add5.done_one_cycle", 64'(res_valid), 64'h0);
    check("add5.idle_ready",     64'(req_ready), 64'h1);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, trace);
    check("ripple.lat",    64'(lat),    64'd8);
    check("ripple.result", 64'(result), 64'h0000_0000);
    check("ripple.cout",   64'(cout),   64'h1);
    check("ripple.ovf",    64'(ovf),    64'h0);
    check("ripple.add_ci", 64'(trace),  64'hFE);
    @(posedge clk); #1;

    run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, lat, trace);
    check("povf.result", 64'(result), 64'h8000_0000);
    check("povf.cout",   64'(cout),   64'h0);
    check("povf.ovf",    64'(ovf),    64'h1);
    @(posedge clk); #1;

    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, lat, trace);
    check("novf.result", 64'(result), 64'h7FFF_FFFF);
    check("novf.cout",   64'(cout),   64'h1);
    check("novf.ovf",    64'(ovf),    64'h1);
    check("novf.add_ci0", 64'(trace[0]), 64'h1);
    @(posedge clk); #1;

    run_op(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, lat, trace);
    check("sub35.result", 64'(result), 64'hFFFF_FFFE);
    check("sub35.cout",   64'(cout),   64'h0);
    check("sub35.ovf",    64'(ovf),    64'h0);
    @(posedge clk); #1;

    res_ready = 1'b0;
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, lat, trace);
    check("hold.lat", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i == 2);
      op_a = 32'hDEAD_BEEF; op_b = 32'h1111_1111; cin = 1'b1; sub = 1'b0;
      @(posedge clk); #1;
      check($sformatf("hold%0d.res_valid", i), 64'(res_valid), 64'h1);
      check($sformatf("hold%0d.result", i),    64'(result),    64'h0000_0030);
      check($sformatf("hold%0d.cout", i),      64'(cout),      64'h0);
      check($sformatf("hold%0d.req_ready", i), 64'(req_ready), 64'h0);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("release.res_valid", 64'(res_valid), 64'h0);
    check("release.req_ready", 64'(req_ready), 64'h1);
    check("release.result",    64'(result),    64'h0000_0030);
    run_op(32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0, lat, trace);
    check("after_hold.lat",    64'(lat),    64'd8);
    check("after_hold.result", 64'(result), 64'h0000_0123);
    @(posedge clk); #1;

    // Abort an add mid-flight at pass 4.
    op_a = 32'h1234_5678; op_b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("abort.pass4_r1", 64'(add_r1), 64'h4);
    check("abort.pass4_r2", 64'(add_r2), 64'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    check("abort.no_result", 64'(res_valid), 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, lat, trace);
    check("post_reset.lat",    64'(lat),    64'd8);
    check("post_reset.result", 64'(result), 64'h0000_0003);
    check("post_reset.cout",   64'(cout),   64'h0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
